// File: rtl/huff_pkg.sv
// huff_pkg: shared chunk constants, FSM state encoding and chunk sizing for the Huffman front end
package huff_pkg;
  localparam int CHUNK_W = 4;
  localparam int MAX_CODE = 9;
  localparam int LEN_W = 3;
  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;
  function automatic logic [LEN_W-1:0] chunk_len(input logic [7:0] left);
    return left >= 8'(CHUNK_W) ? LEN_W'(CHUNK_W) : left[LEN_W-1:0];
  endfunction
endpackage

// File: rtl/huff_word_slot.sv
// huff_word_slot: word/bit-count/last register; clear_i > load_i (word_i, bits_i, last_i) > shift_i by shamt_i; outputs word_o, bits_o, last_o, valid_o
module huff_word_slot
  import huff_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [LEN_W-1:0]  shamt_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [CNT_W-1:0]  bits_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] word_o,
  output logic [CNT_W-1:0]  bits_o,
  output logic              last_o,
  output logic              valid_o
);
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] bits_q, bits_d, left;
  logic last_q, last_d, valid_q, valid_d;
  always_comb begin
    left = bits_q - CNT_W'(shamt_i);
    word_d = clear_i ? '0 : load_i ? word_i : shift_i ? word_q >> shamt_i : word_q;
    bits_d = clear_i ? '0 : load_i ? bits_i : shift_i ? left : bits_q;
    last_d = clear_i ? 1'b0 : load_i ? last_i : last_q;
    valid_d = clear_i ? 1'b0 : load_i ? 1'b1 : shift_i ? left != '0 : valid_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      bits_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      word_q <= word_d;
      bits_q <= bits_d;
      last_q <= last_d;
      valid_q <= valid_d;
    end
  end
  assign word_o = word_q;
  assign bits_o = bits_q;
  assign last_o = last_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/huff_chunk_feeder.sv
// huff_chunk_feeder: slices packed words (word_valid/data/bits/last, word_ready) LSB-first into 1-4 bit chunks (svalid, in_data, in_len) acked by load_bits; stream_done pulses after the last chunk
module huff_chunk_feeder
  import huff_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               word_valid,
  input  logic [WORD_W-1:0]  word_data,
  input  logic [CNT_W-1:0]   word_bits,
  input  logic               word_last,
  output logic               word_ready,
  output logic               svalid,
  output logic [CHUNK_W-1:0] in_data,
  output logic [LEN_W-1:0]   in_len,
  input  logic               load_bits,
  output logic               stream_done
);
  logic [0:0] state_q, state_d;
  logic [WORD_W-1:0] cur_word, pf_word, ld_word;
  logic [CNT_W-1:0] cur_bits, pf_bits, ld_bits, in_sat;
  logic cur_last, cur_valid, pf_last, pf_valid, ld_last;
  logic accept, consume, emptying, free, from_pf, take, go_done;
  logic cur_load, pf_load, pf_clear;
  logic unused_hi;
  always_comb begin
    in_sat = word_bits > CNT_W'(WORD_W) ? CNT_W'(WORD_W) : word_bits;
    word_ready = !pf_valid && state_q == S_RUN;
    accept = word_valid && word_ready;
    consume = load_bits && cur_valid;
    emptying = consume && cur_bits <= CNT_W'(CHUNK_W);
    free = !cur_valid || emptying;
    from_pf = free && pf_valid;
    ld_word = from_pf ? pf_word : word_data;
    ld_bits = from_pf ? pf_bits : in_sat;
    ld_last = from_pf ? pf_last : word_last;
    take = free && (from_pf || accept);
    go_done = (emptying && cur_last) || (take && ld_bits == '0 && ld_last);
    cur_load = take && ld_bits != '0 && !go_done;
    pf_clear = go_done || from_pf;
    pf_load = accept && !free && (in_sat != '0 || word_last);
    state_d = go_done ? S_DONE : S_RUN;
  end
  huff_word_slot #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_cur (
    .clk(clk), .reset(reset), .clear_i(go_done), .load_i(cur_load), .shift_i(consume),
    .shamt_i(in_len), .word_i(ld_word), .bits_i(ld_bits), .last_i(ld_last),
    .word_o(cur_word), .bits_o(cur_bits), .last_o(cur_last), .valid_o(cur_valid)
  );
  huff_word_slot #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_pf (
    .clk(clk), .reset(reset), .clear_i(pf_clear), .load_i(pf_load), .shift_i(1'b0),
    .shamt_i('0), .word_i(word_data), .bits_i(in_sat), .last_i(word_last),
    .word_o(pf_word), .bits_o(pf_bits), .last_o(pf_last), .valid_o(pf_valid)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else state_q <= state_d;
  end
  assign svalid = cur_valid;
  assign in_len = chunk_len(8'(cur_bits));
  assign in_data = cur_word[CHUNK_W-1:0] & ~({CHUNK_W{1'b1}} << in_len);
  assign stream_done = state_q == S_DONE;
  assign unused_hi = ^cur_word[WORD_W-1:CHUNK_W];
endmodule
